// File: rtl/axil_regfile_responder_if.sv
// AXI4-Lite bus bundle shared by the register-file responder and its master.
// The responder connects through the slave modport; BFMs and interconnects use master.
interface axil_regfile_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axil_regfile_responder.sv
// AXI4-Lite register-file responder with independent write and read FSMs and byte strobes.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_regfile_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    axil_regfile_responder_if.slave                s_axi,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = AW - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_RESP } rd_state_t;

    logic [DW-1:0] regs [NUM_REGS];

    wr_state_t     wr_state, wr_state_d;
    logic          aw_held, aw_held_d, w_held, w_held_d;
    logic [IW-1:0] awidx_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;

    logic          aw_hs, w_hs, commit;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [NUM_REGS-1:0] wr_hit;
    logic [1:0]    wr_resp;

    rd_state_t     rd_state, rd_state_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d, rd_word;
    logic [1:0]    rresp_q, rresp_d, rd_resp;
    logic          ar_hs;
    logic [IW-1:0] rd_idx;
    logic [NUM_REGS-1:0] rd_hit;

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // ---------------- write path ----------------
    assign aw_hs   = s_axi.awvalid & awready_q;
    assign w_hs    = s_axi.wvalid & wready_q;
    assign wr_idx  = aw_held ? awidx_q : s_axi.awaddr[AW-1:2];
    assign wr_data = w_held ? wdata_q : s_axi.wdata;
    assign wr_strb = w_held ? wstrb_q : s_axi.wstrb;
    assign commit  = (wr_state == WR_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (wr_idx == IW'(i));
            rd_hit[i] = (rd_idx == IW'(i));
        end
    end

`ifdef AXIL_REGFILE_SLVERR_EN
    assign wr_resp = (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        // NOTE: every clocked assignment is non-blocking so all flops sample pre-edge values together.
        if (!S_AXI_ARESETN) begin
            wr_state  <= WR_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state  <= wr_state_d;
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // NOTE: payload holding registers need no reset; the held flags qualify them.
    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) awidx_q <= s_axi.awaddr[AW-1:2];
        if (w_hs) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
        end
    end

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        wr_state_d = wr_state;
        case (wr_state)
            WR_IDLE: if (commit) wr_state_d = WR_RESP;
            WR_RESP: if (s_axi.bready) wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        aw_held_d = aw_held;
        w_held_d  = w_held;
        bresp_d   = bresp_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp;
                end else begin
                    aw_held_d = aw_held | aw_hs;
                    w_held_d  = w_held | w_hs;
                    awready_d = ~(aw_held | aw_hs);
                    wready_d  = ~(w_held | w_hs);
                end
            end
            WR_RESP: begin
                if (s_axi.bready) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    bvalid_d  = 1'b1;
                end
            end
        endcase
    end

    // The register bank is architecturally visible, so it is cleared on reset.
    always_ff @(posedge S_AXI_ACLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!S_AXI_ARESETN) begin
                regs[i] <= '0;
            end else if (commit && wr_hit[i]) begin
                for (int b = 0; b < SW; b++) begin
                    if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    assign ar_hs  = s_axi.arvalid & arready_q;
    assign rd_idx = s_axi.araddr[AW-1:2];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit[i]) rd_word = regs[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rd_state  <= rd_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (s_axi.rready) rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (rd_state_d == RD_IDLE);
        rvalid_d  = (rd_state_d == RD_RESP);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs) begin
            rdata_d = rd_word;
            rresp_d = rd_resp;
        end
    end

    // ---------------- outputs ----------------
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[DW*i +: DW] = regs[i];
    end
endmodule

// File: doc/axil_regfile_responder.md
# axil_regfile_responder

AXI4-Lite slave (responder) exposing a bank of 32-bit registers to the AXI4-Lite master BFM in the block-design testbench, and to the processor interconnect in the Splitter design. Accepts single-beat writes and reads, honours byte strobes, runs independent write and read channels, and reports out-of-range accesses. It terminates the write/read bursts issued by the master, and its register outputs feed the Splitter datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte-address width; the register index is addr[C_S_AXI_ADDR_WIDTH-1:2].
- NUM_REGS, 4, implemented registers; NUM_REGS is at most 2^(C_S_AXI_ADDR_WIDTH-2).
- S_AXI_ACLK  in  1  sole clock; everything is sampled on the rising edge.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- reg_out  out  32*NUM_REGS  flattened register contents; register i occupies bits [32i+31:32i].

## Operation
- Reset (ARESETN=0 at a clock edge):
  - All registers clear to 0x00000000.
  - Every READY and VALID output drives 0.
  - BRESP, RRESP and RDATA drive 0.
  - Both FSMs return to IDLE.
  - Reset asserted mid-transaction aborts it: no register update, no response issued.
- Write FSM: WR_IDLE -> WR_RESP -> WR_IDLE.
  - In WR_IDLE, AWREADY=1 until an address is latched and WREADY=1 until data is latched; the two channels are accepted independently and in either order.
  - When both address and data are held (including both handshaking in the same cycle), the write commits on that edge.
  - Commit: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA[8b+7:8b]. WSTRB=0000 is legal; it changes nothing and responds OKAY.
  - The FSM then enters WR_RESP with BVALID=1 and AWREADY=WREADY=0.
  - BVALID and BRESP hold until BREADY=1, then the FSM returns to WR_IDLE and the latch flags clear.
- Read FSM: RD_IDLE -> RD_RESP -> RD_IDLE.
  - In RD_IDLE, ARREADY=1.
  - On the AR handshake, RDATA is loaded with reg[idx] as it stood before that edge, and the FSM enters RD_RESP with RVALID=1 and ARREADY=0.
  - RDATA and RRESP hold stable until RREADY=1, then the FSM returns to RD_IDLE.
- Simultaneous write commit and read address handshake to the same register: the read returns the old value; the new value is visible to the next read.
- Out-of-range index (idx >= NUM_REGS): see Configuration.
- Address bits [1:0] are ignored. Accesses are always full-word aligned.

## Timing
- Write latency: commit at edge N, where N is the later of the AW and W handshake edges. BVALID=1 from N until the edge where BREADY is sampled high.
- Minimum write cycle is 2 clocks: handshake, then a response with BREADY=1. Back-to-back, AWREADY returns to 1 in the cycle after the B handshake.
- Read latency: AR handshake at edge N, RVALID=1 in the following cycle. Minimum read cycle is 2 clocks.
- reg_out updates at the commit edge, 0 cycles after commit.
- READY signals never depend combinationally on VALID signals. All outputs are registered.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined:
  - An out-of-range write is dropped and returns BRESP=2'b10 (SLVERR).
  - An out-of-range read returns RDATA=0 with RRESP=2'b10.
- AXIL_REGFILE_SLVERR_EN undefined:
  - Out-of-range writes are dropped and reads return 0, both with OKAY (2'b00).
  - The index is decoded only over the implemented range.
- In-range accesses respond OKAY in both builds.

## Test plan
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011 and 0xbeef0011 to 0x00, 0x04, 0x08 and 0x0C, reading each back -> every BRESP and RRESP is 0 and each read data equals the value written.
- Write 0xFFFFFFFF to 0x04, then write 0x12345678 with WSTRB=0101 -> read of 0x04 returns 0xFF34FF78; reg_out[63:32] equals 0xFF34FF78.
- W presented 3 cycles before AW, with BREADY held low for 4 cycles -> a single commit; BVALID stays high with stable BRESP and AWREADY/WREADY stay 0 until BREADY rises.
- Read and write to 0x08 handshake in the same cycle, old value 0xdead0011, new value 0x55AA55AA -> that read returns 0xdead0011 and the next read returns 0x55AA55AA.
- Access address 0x10 -> with AXIL_REGFILE_SLVERR_EN, BRESP=RRESP=2'b10 and RDATA=0; without it, both responses are 2'b00 and RDATA=0; registers 0-3 are unchanged in both builds.
- Assert ARESETN low for one edge while BVALID=1 and registers are nonzero -> the next cycle BVALID=0, all registers read 0, and AWREADY/WREADY/ARREADY=0 during reset and 1 after release.
